load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage that sits directly downstream of the ALU. It consumes the ALU's effective `address` plus `rs2_val`, and runs one request/ready transaction on the data bus per load or store. Loads return aligned, sign- or zero-extended data for write-back. The block holds `should_stall` high for the whole transaction, so the core's FSM stays in the memory-access state until the access completes, is rejected as misaligned, or times out.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent waiting for `mem_ready` before the access is abandoned. Range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `state`  in  3  core FSM state, encoded with the shared constants.
- `is_load`  in  1  decoded load.
- `is_store`  in  1  decoded store.
- `funct3`  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `address`  in  32  effective address from the ALU.
- `rs2_val`  in  32  store data.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address, `{address[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte enables; 0 for reads.
- `mem_ready`  in  1  bus completion; read data is valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `load_data`  out  32  extended load result.
- `misaligned`  out  1  set when the access was rejected as misaligned.
- `bus_err`  out  1  set when the access timed out.
- `should_stall`  out  1  core must hold its state.

## Operation
FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - Trigger: `state == MEM_ACCESS` and (`is_load` | `is_store`).
  - Misaligned access → DONE with `misaligned=1` and no bus activity. Misaligned means: h/hu/sh with `address[0]=1`, or w/sw with `address[1:0]!=0`.
  - Aligned access → REQ. Latch `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb`, funct3 and `address[1:0]`; clear the timeout counter.
- **REQ**
  - `mem_req=1`. Go to WAIT.
- **WAIT**
  - `mem_req` stays 1 and the outputs stay stable.
  - On `mem_ready`: drop `mem_req`, capture the extracted load data, go to DONE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT_CYCLES`: drop `mem_req`, set `bus_err=1`, `load_data=0`, go to DONE.
- **DONE**
  - Hold results. Return to IDLE once `state != MEM_ACCESS`.
  - `misaligned` and `bus_err` are cleared on the next trigger.
- Store lanes:
  - sb: `wdata={4{rs2[7:0]}}`, `wstrb=4'b0001<<address[1:0]`.
  - sh: `wdata={2{rs2[15:0]}}`, `wstrb=4'b0011<<{address[1],1'b0}`.
  - sw: `wstrb=4'b1111`.
- Load extraction from `mem_rdata`:
  - b/bu: byte `address[1:0]`, sign- or zero-extended.
  - h/hu: halfword `address[1]`, sign- or zero-extended.
  - w: the full word.
  - A store completing leaves `load_data` unchanged.
- `should_stall` is combinational: (trigger condition) && FSM != DONE. It is therefore high in the trigger cycle itself.
- Unsupported funct3 values (011, 110, 111) are treated as misaligned.

## Timing
- Reset (asynchronous): FSM=IDLE, counter=0, and every output is 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `load_data`, `misaligned`, `bus_err`). `should_stall` follows its equation.
- Reset mid-transaction drops `mem_req` immediately. A `mem_ready` that arrives afterwards is ignored.
- Minimum latency, trigger to DONE: 3 edges with `mem_ready` in the first WAIT cycle. `load_data` is valid from the DONE cycle.
- Misaligned: DONE after 1 edge. `should_stall` is high for that 1 cycle only.
- `mem_ready` is ignored outside WAIT. `mem_ready` in the same cycle as the timeout counts as success.
- Timeout: `bus_err` rises after `TIMEOUT_CYCLES` WAIT cycles without `mem_ready`.
- If `state` leaves MEM_ACCESS while in REQ or WAIT, the transaction completes anyway. Abort is not supported.

## Structure
- FSM state encoding, funct3 width codes, and the `MEM_ACCESS` core-state constant go in `constant_defs.v`.
- One sub-module, `load_extend`: purely combinational byte/half selection and sign/zero extension. It is shared with future atomics.

## Test plan
- lw at 0x100, `mem_rdata=0xDEADBEEF`, ready in the first WAIT cycle → `mem_addr=0x100`, `load_data=0xDEADBEEF`, `should_stall` high for exactly 3 cycles.
- lb at 0x103 with rdata 0x80112233 → `load_data=0xFFFFFF80`. lbu at the same address → `0x00000080`.
- sh at 0x202, `rs2_val=0x1234ABCD` → `mem_addr=0x200`, `wdata=0xABCDABCD`, `wstrb=4'b1100`, `mem_we=1`.
- sw at 0x201 → `misaligned=1`, `mem_req` never asserted, `should_stall` high for 1 cycle.
- `TIMEOUT_CYCLES=4`, ready never asserted → `bus_err=1`, `load_data=0`, `mem_req` low after 4 WAIT cycles. Ready on the 4th WAIT cycle → success, `bus_err=0`.
- `rst_n` low during WAIT → `mem_req` drops asynchronously; after release, a new lw completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the memory-access stage: core state codes, funct3
// width codes, LSU FSM encoding and the store-lane helpers.
package load_store_unit_pkg;

    // Core FSM state codes; MEM_ACCESS is the only one this stage reacts to.
    localparam logic [2:0] CORE_FETCH     = 3'd0;
    localparam logic [2:0] CORE_DECODE    = 3'd1;
    localparam logic [2:0] CORE_EXECUTE   = 3'd2;
    localparam logic [2:0] MEM_ACCESS     = 3'd3;
    localparam logic [2:0] CORE_WRITEBACK = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // Unsupported width codes are folded into the misaligned rejection.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] width,
                                                input logic [31:0] rs2);
        case (width)
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] width,
                                              input logic [1:0] addr_lo);
        case (width)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational byte/halfword selection and sign/zero extension of a read
// word; kept standalone so atomics can reuse it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (byte_off)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   data = {24'h000000, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   data = {16'h0000, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/ready bus transaction per load or store,
// with misalignment rejection, timeout and extended load write-back data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] rs2_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        should_stall
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    // Bus handshake: mem_req rises on the trigger edge and stays high, with
    // address/data/strobes stable, through REQ and WAIT. Only a mem_ready seen
    // in WAIT completes the transfer; mem_req drops on that same edge.
    lsu_state_t  fsm_state;
    lsu_state_t  fsm_next;
    logic [7:0]  wait_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        trigger;
    logic        access_bad;
    logic        ready_hit;
    logic        timeout_hit;
    logic [31:0] ext_data;

    assign trigger      = (state == MEM_ACCESS) && (is_load || is_store);
    assign access_bad   = access_misaligned(funct3, address[1:0]);
    assign should_stall = trigger && (fsm_state != LSU_DONE);
    assign ready_hit    = (fsm_state == LSU_WAIT) && mem_ready;
    // A ready arriving in the final WAIT cycle wins over the timeout.
    assign timeout_hit  = (fsm_state == LSU_WAIT) && !mem_ready
                          && ((wait_cnt + 8'd1) >= TIMEOUT_LIMIT);

    load_extend u_load_extend (
        .funct3   (funct3_q),
        .byte_off (off_q),
        .rdata    (mem_rdata),
        .data     (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= LSU_IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            LSU_IDLE: begin
                if (trigger) begin
                    fsm_next = access_bad ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ:  fsm_next = LSU_WAIT;
            LSU_WAIT: begin
                if (ready_hit || timeout_hit) begin
                    fsm_next = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (state != MEM_ACCESS) begin
                    fsm_next = LSU_IDLE;
                end
            end
            default:  fsm_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'h0;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            wait_cnt   <= 8'h0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
        end else begin
            case (fsm_state)
                LSU_IDLE: begin
                    if (trigger) begin
                        misaligned <= access_bad;
                        bus_err    <= 1'b0;
                        if (!access_bad) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {address[31:2], 2'b00};
                            mem_wdata <= store_wdata(funct3[1:0], rs2_val);
                            mem_wstrb <= is_store ? store_strb(funct3[1:0], address[1:0])
                                                  : 4'b0000;
                            funct3_q  <= funct3;
                            off_q     <= address[1:0];
                            wait_cnt  <= 8'h0;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (ready_hit) begin
                        mem_req <= 1'b0;
                        // Stores leave the previous write-back value in place.
                        if (!mem_we) begin
                            load_data <= ext_data;
                        end
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        load_data <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses from the test plan followed by
// random loads/stores with random ready delays, scored against a byte-level model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] rs2_val;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;
    logic        should_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_load_data = 32'h0;
    logic [33:0] exp_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .is_load      (is_load),
        .is_store     (is_store),
        .funct3       (funct3),
        .address      (address),
        .rs2_val      (rs2_val),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .should_stall (should_stall)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = acc_size(f3);
        return (sz == 0) || ((addr % sz) != 0);
    endfunction

    function automatic logic [31:0] model_extend(input logic [2:0] f3, input logic [31:0] addr,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * (addr % 4));
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'h0, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd5:    return {16'h0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        logic [31:0] mv;
        m  = ((1 << acc_size(f3)) - 1) << (addr % 4);
        mv = 32'(m);
        return mv[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (acc_size(f3))
            1:       return {4{rs2[7:0]}};
            2:       return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    // ---------------- driver ----------------
    // delay = number of WAIT cycles before mem_ready (0 = first WAIT cycle);
    // delay >= TMO means the bus never answers.
    task automatic run_access(input string tag, input bit ld, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int delay);
        bit          bad;
        int          exp_len;
        int          last_req;
        int          k;
        logic [33:0] exp;
        bad = model_misaligned(f3, addr);
        if (bad) begin
            exp_len  = 1;
            last_req = 0;
            exp      = {1'b1, 1'b0, model_load_data};
        end else if (delay < TMO) begin
            exp_len  = 3 + delay;
            last_req = 2 + delay;
            if (ld) model_load_data = model_extend(f3, addr, rdata);
            exp      = {2'b00, model_load_data};
        end else begin
            exp_len  = 2 + TMO;
            last_req = 1 + TMO;
            model_load_data = 32'h0;
            exp      = {2'b01, 32'h0};
        end
        exp_q.push_back(exp);

        @(negedge clk);
        state     = MEM_ACCESS;
        is_load   = ld;
        is_store  = !ld;
        funct3    = f3;
        address   = addr;
        rs2_val   = rs2;
        mem_rdata = rdata;
        mem_ready = 1'b0;
        #1;
        check({tag, " stall_trigger"}, 32'(should_stall), 32'd1);

        k = 0;
        while (k < exp_len + 4) begin
            @(negedge clk);
            k++;
            check({tag, " mem_req"}, 32'(mem_req), 32'(k <= last_req));
            if (k <= last_req) begin
                check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                check({tag, " mem_we"}, 32'(mem_we), 32'(!ld));
                check({tag, " mem_wstrb"}, 32'(mem_wstrb), ld ? 32'h0 : 32'(model_strb(f3, addr)));
                if (!ld) check({tag, " mem_wdata"}, mem_wdata, model_wdata(f3, rs2));
            end
            if (!should_stall) break;
            mem_ready = (k == 2 + delay);
        end
        check({tag, " stall_cycles"}, 32'(k), 32'(exp_len));

        exp = exp_q.pop_front();
        check({tag, " misaligned"}, 32'(misaligned), 32'(exp[33]));
        check({tag, " bus_err"}, 32'(bus_err), 32'(exp[32]));
        check({tag, " load_data"}, load_data, exp[31:0]);

        mem_ready = 1'b0;
        state     = CORE_WRITEBACK;
        is_load   = 1'b0;
        is_store  = 1'b0;
        @(negedge clk);
        check({tag, " stall_after"}, 32'(should_stall), 32'd0);
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        state     = MEM_ACCESS;
        is_load   = 1'b1;
        is_store  = 1'b0;
        funct3    = F3_W;
        address   = 32'h0000_0040;
        mem_rdata = 32'hCAFE_F00D;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid req_async", 32'(mem_req), 32'd0);
        check("rst_mid load_data", load_data, 32'h0);
        check("rst_mid addr", mem_addr, 32'h0);
        model_load_data = 32'h0;
        state     = CORE_FETCH;
        is_load   = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid late_ready", 32'(mem_req), 32'd0);
            check("rst_mid late_data", load_data, 32'h0);
        end
        mem_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        state     = CORE_FETCH;
        is_load   = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'b000;
        address   = 32'h0;
        rs2_val   = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("reset load_data", load_data, 32'h0);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        check("reset stall_idle", 32'(should_stall), 32'd0);
        state   = MEM_ACCESS;
        is_load = 1'b1;
        #1;
        check("reset stall_eq", 32'(should_stall), 32'd1);
        state   = CORE_FETCH;
        is_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_access("lw_100", 1'b1, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        check("lw_100 literal", load_data, 32'hDEADBEEF);
        run_access("lb_103", 1'b1, F3_B, 32'h103, 32'h0, 32'h80112233, 0);
        check("lb_103 literal", load_data, 32'hFFFFFF80);
        run_access("lbu_103", 1'b1, F3_BU, 32'h103, 32'h0, 32'h80112233, 1);
        check("lbu_103 literal", load_data, 32'h00000080);
        run_access("sh_202", 1'b0, F3_H, 32'h202, 32'h1234ABCD, 32'h0, 0);
        run_access("sw_201", 1'b0, F3_W, 32'h201, 32'h55AA55AA, 32'h0, 0);
        run_access("lw_timeout", 1'b1, F3_W, 32'h300, 32'h0, 32'h11111111, 99);
        run_access("lw_last_wait", 1'b1, F3_W, 32'h304, 32'h0, 32'h22223333, TMO - 1);
        run_access("lhu_bad_f3", 1'b1, 3'b011, 32'h308, 32'h0, 32'h0, 0);

        reset_mid_wait();
        run_access("lw_after_rst", 1'b1, F3_W, 32'h400, 32'h0, 32'hA5A5_0F0F, 0);

        for (int i = 0; i < 200; i++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          sel;
            ld  = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            if (ld) begin
                case (sel)
                    0, 1:    f3 = F3_B;
                    2, 3:    f3 = F3_BU;
                    4:       f3 = F3_H;
                    5:       f3 = F3_HU;
                    6, 7:    f3 = F3_W;
                    8:       f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
            end else begin
                f3 = 3'(sel % 3);
            end
            addr = $urandom();
            // Bias toward aligned addresses so most accesses reach the bus.
            if ($urandom_range(0, 3) != 0) begin
                if (acc_size(f3) == 2) addr[0] = 1'b0;
                if (acc_size(f3) == 4) addr[1:0] = 2'b00;
            end
            run_access("rand", ld, f3, addr, $urandom(), $urandom(), $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
